// File: rtl/bcd_to_bin_decoder.sv
// Packed-BCD to binary converter, one digit per cycle, MSD first.
// Define BCD2BIN_ERR_CHECK_EN to flag nibbles > 9 and zero the result.
module bcd_to_bin_decoder #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      out_bin,
  output logic                  out_err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (BIN_W < $clog2(10 ** DIGITS)) begin : g_bad_width
    $error("BIN_W too small for DIGITS");
  end

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [4*DIGITS-1:0] bcd_q;
  logic [BIN_W-1:0]    acc;
  logic [IW-1:0]       idx;
  logic                armed;
  logic [3:0]          nib;
  logic                take;

  // armed keeps in_ready low through reset and its release cycle
  assign in_ready  = armed && (state == IDLE);
  assign out_valid = (state == DONE);
  assign take      = in_valid && in_ready;
  assign nib       = 4'(bcd_q >> {idx, 2'b00});

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (take) state_nx = CONV;
      CONV: if (idx == '0) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      armed <= 1'b0;
      bcd_q <= '0;
      acc   <= '0;
      idx   <= '0;
    end else begin
      armed <= 1'b1;
      state <= state_nx;
      if (state == IDLE && take) begin
        bcd_q <= in_bcd;
        acc   <= '0;
        idx   <= IW'(DIGITS - 1);
      end else if (state == CONV) begin
        acc <= (acc << 3) + (acc << 1) + BIN_W'(nib);
        if (idx != '0) idx <= idx - 1'b1;
      end
    end
  end

`ifdef BCD2BIN_ERR_CHECK_EN
  logic err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (state == IDLE && take) begin
      err <= 1'b0;
    end else if (state == CONV) begin
      err <= err | (nib > 4'd9);
    end
  end

  assign out_err = err;
  assign out_bin = err ? '0 : acc;
`else
  assign out_err = 1'b0;
  assign out_bin = acc;
`endif

endmodule
